// File: rtl/usr_rx.sv
// Framed serial receiver: start, WIDTH data bits, even parity, stop, sampled on en strobes.
// Good words are held in PO with a valid/ready handshake; errors are reported as 1-cycle pulses.
module usr_rx #(
    parameter int unsigned WIDTH     = 5,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SI,
    input  logic             en,
    output logic [WIDTH-1:0] PO,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic             valid_q, valid_d;
    logic             par_ok_q, par_ok_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             good;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        po_d     = po_q;
        valid_d  = valid_q;
        par_ok_d = par_ok_q;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        good     = 1'b0;

        case (state_q)
            StIdle: begin
                if (en && !SI) begin
                    state_d = StData;
                    cnt_d   = '0;
                end
            end
            StData: begin
                if (en) begin
                    if (MSB_FIRST) sr_d = (sr_q << 1) | WIDTH'(SI);
                    else           sr_d = (sr_q >> 1) | (WIDTH'(SI) << (WIDTH - 1));
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) state_d = StParity;
                end
            end
            StParity: begin
                if (en) begin
                    par_ok_d = ~(^sr_q ^ SI);
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (en) begin
                    state_d = StIdle;
                    // A bad stop bit masks any parity error.
                    if (!SI)            ferr_d = 1'b1;
                    else if (!par_ok_q) perr_d = 1'b1;
                    else                good   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (valid_q && ready) valid_d = 1'b0;
        if (good) begin
            if (!valid_q || ready) begin
                po_d    = sr_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sr_q     <= '0;
            po_q     <= '0;
            valid_q  <= 1'b0;
            par_ok_q <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            po_q     <= po_d;
            valid_q  <= valid_d;
            par_ok_q <= par_ok_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign PO         = po_q;
    assign valid      = valid_q;
    assign busy       = (state_q != StIdle);
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule
